tdpram_port_arbiter: RTL and testbench

- Shares one true dual-port block RAM between NUM_REQ requesters.
- Each cycle, grants up to two requests in round-robin order: the first winner goes to RAM port A, the second to port B.
- Blocks same-address write collisions.
- Routes each registered RAM read result back to the requester that issued it, with a one-cycle valid.

---
 rtl/tdpram_arb_pkg.sv | 43 ++++
 rtl/tdpram_rr_picker.sv | 31 +++
 rtl/tdpram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_tdpram_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdpram_arb_pkg.sv
// -----------------------------------------------------------------------------
// tdpram_arb_pkg
// Shared definitions for the true-dual-port RAM arbiter:
//   - default sizing constants for the requester count and the RAM geometry
//   - rr_pick(): cyclic first-one search over a request vector, starting at a
//     given index. It returns a found flag and the winning index.
// Request vectors are zero-extended to MAX_REQ bits by the caller, so a single
// function serves every legal NUM_REQ (2..8).
// -----------------------------------------------------------------------------
package tdpram_arb_pkg;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_RAM_WIDTH = 16;
   localparam int DEF_RAM_DEPTH = 1024;

   localparam int MAX_REQ = 8;
   localparam int MAX_IW  = 3;

   typedef struct packed {
      logic              found;
      logic [MAX_IW-1:0] idx;
   } rr_pick_t;

   // Scan req cyclically from 'start' over the first n entries and return
   // the first set position. The loop bound is the fixed MAX_REQ; the
   // o < n guard trims the scan to the live requesters.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                        input logic [MAX_IW-1:0]  start,
                                        input int unsigned        n);
      rr_pick_t          r;
      logic [MAX_IW-1:0] c;
      r = '0;
      for (int unsigned o = 0; o < MAX_REQ; o++) begin
         c = MAX_IW'((32'(start) + o) % n);
         if ((o < n) && !r.found && req[c]) begin
            r.found = 1'b1;
            r.idx   = c;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tdpram_rr_picker.sv
// -----------------------------------------------------------------------------
// tdpram_rr_picker
// Combinational cyclic first-one finder. It is used twice by the arbiter:
// once for the port-A winner and once for the port-B winner.
// Ports:
//   req    in  N        request vector
//   start  in  IW       index the scan begins at (inclusive)
//   found  out 1        at least one request bit was set
//   idx    out IW       first requesting index at or after start, wrapping
// -----------------------------------------------------------------------------
module tdpram_rr_picker
   import tdpram_arb_pkg::*;
#(
   parameter  int N  = DEF_NUM_REQ,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   rr_pick_t pick;

   always_comb begin
      pick  = rr_pick(MAX_REQ'(req), MAX_IW'(start), N);
      found = pick.found;
      idx   = IW'(pick.idx);
   end

endmodule

// File: rtl/tdpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tdpram_port_arbiter
// Shares one true dual-port block RAM between NUM_REQ requesters. Each cycle
// up to two requests are granted in round-robin order: the first winner drives
// RAM port A and the second drives port B. A same-address pair involving a
// write is split across cycles by dropping the B grant. Read results from the
// RAM's registered outputs are steered back to the requester that issued them.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req/req_we            per-requester request and write(1)/read(0) select
//   req_addr/req_wdata    flattened per-requester address and write data
//   gnt                   combinational grant (one or two bits set)
//   rvalid/rdata          per-requester read return, rvalid lasts one cycle
//   ram_*_a / ram_*_b     RAM port A / port B enables, address, data
// -----------------------------------------------------------------------------
module tdpram_port_arbiter
   import tdpram_arb_pkg::*;
#(
   parameter  int NUM_REQ   = DEF_NUM_REQ,
   parameter  int RAM_WIDTH = DEF_RAM_WIDTH,
   parameter  int RAM_DEPTH = DEF_RAM_DEPTH,
   localparam int AW        = $clog2(RAM_DEPTH),
   localparam int IW        = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*AW-1:0]          req_addr,
   input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             rvalid,
   output logic [NUM_REQ*RAM_WIDTH-1:0]   rdata,
   output logic                           ram_we_a,
   output logic                           ram_re_a,
   output logic [AW-1:0]                  ram_addr_a,
   output logic [RAM_WIDTH-1:0]           ram_din_a,
   input  logic [RAM_WIDTH-1:0]           ram_dout_a,
   output logic                           ram_we_b,
   output logic                           ram_re_b,
   output logic [AW-1:0]                  ram_addr_b,
   output logic [RAM_WIDTH-1:0]           ram_din_b,
   input  logic [RAM_WIDTH-1:0]           ram_dout_b
);

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   logic [AW-1:0]        addr_arr  [NUM_REQ];
   logic [RAM_WIDTH-1:0] wdata_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*AW +: AW];
      assign wdata_arr[g] = req_wdata[g*RAM_WIDTH +: RAM_WIDTH];
   end

   logic [IW-1:0]      rr_ptr;
   logic               a_found, b_found;
   logic [IW-1:0]      a_idx, b_idx, b_start;
   logic [NUM_REQ-1:0] req_b;
   logic               conflict, gnt_a, gnt_b;

   // ---- stage p0: arbitration and RAM port drive (combinational) ----
   tdpram_rr_picker #(.N(NUM_REQ)) u_pick_a (
      .req   (req),
      .start (rr_ptr),
      .found (a_found),
      .idx   (a_idx)
   );

   // B searches the remaining requesters starting just after A. A itself is
   // masked out, so the wrap-around scan naturally stops before reaching A.
   always_comb begin
      req_b        = req;
      req_b[a_idx] = 1'b0;
      b_start      = next_idx(a_idx);
   end

   tdpram_rr_picker #(.N(NUM_REQ)) u_pick_b (
      .req   (req_b),
      .start (b_start),
      .found (b_found),
      .idx   (b_idx)
   );

   // A deferred B is not replaced by a later requester. It simply waits,
   // and the pointer moves past A so B leads the scan next cycle.
   always_comb begin
      conflict = (addr_arr[a_idx] == addr_arr[b_idx]) &&
                 (req_we[a_idx] || req_we[b_idx]);
      gnt_a    = a_found && !rst;
      gnt_b    = b_found && !conflict && !rst;
   end

   always_comb begin
      gnt = '0;
      if (gnt_a) gnt[a_idx] = 1'b1;
      if (gnt_b) gnt[b_idx] = 1'b1;
   end

   always_comb begin
      ram_we_a   = gnt_a && req_we[a_idx];
      ram_re_a   = gnt_a && !req_we[a_idx];
      ram_addr_a = gnt_a ? addr_arr[a_idx]  : '0;
      ram_din_a  = gnt_a ? wdata_arr[a_idx] : '0;
      ram_we_b   = gnt_b && req_we[b_idx];
      ram_re_b   = gnt_b && !req_we[b_idx];
      ram_addr_b = gnt_b ? addr_arr[b_idx]  : '0;
      ram_din_b  = gnt_b ? wdata_arr[b_idx] : '0;
   end

   // ---- stage p1: per-port read tags, aligned with the RAM's registered dout ----
   logic          vld_a_p1, vld_b_p1;
   logic [IW-1:0] tag_a_p1, tag_b_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr   <= '0;
         vld_a_p1 <= 1'b0;
         vld_b_p1 <= 1'b0;
      end else begin
         if (gnt_b)      rr_ptr <= next_idx(b_idx);
         else if (gnt_a) rr_ptr <= next_idx(a_idx);
         vld_a_p1 <= ram_re_a;
         vld_b_p1 <= ram_re_b;
      end
      tag_a_p1 <= a_idx;
      tag_b_p1 <= b_idx;
   end

   logic [NUM_REQ-1:0]   sel_a, sel_b;
   logic [RAM_WIDTH-1:0] rdata_q [NUM_REQ];

   // A requester is never both A and B in one cycle, so at most one port
   // targets a given requester. Reset suppresses a read still in flight.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_a[i] = !rst && vld_a_p1 && (tag_a_p1 == IW'(i));
         sel_b[i] = !rst && vld_b_p1 && (tag_b_p1 == IW'(i));
      end
      rvalid = sel_a | sel_b;
   end

   // The RAM output register is the capture stage: during the valid cycle
   // rdata passes ram_dout straight through, and rdata_q keeps that value
   // until the requester's next read returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_a[i])      rdata_q[i] <= ram_dout_a;
            else if (sel_b[i]) rdata_q[i] <= ram_dout_b;
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_a[i])      rdata[i*RAM_WIDTH +: RAM_WIDTH] = ram_dout_a;
         else if (sel_b[i]) rdata[i*RAM_WIDTH +: RAM_WIDTH] = ram_dout_b;
         else               rdata[i*RAM_WIDTH +: RAM_WIDTH] = rdata_q[i];
      end
   end

endmodule

// File: tb/tb_tdpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tdpram_port_arbiter
// Bench for tdpram_port_arbiter with NUM_REQ=4, 16-bit words, 1024 deep. It
// holds a behavioural dual-port RAM with registered outputs, a reference model
// of the arbitration rules, directed scenarios and a randomized phase.
// -----------------------------------------------------------------------------
module tb_tdpram_port_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 10;

   logic            clk = 1'b0;
   logic            rst;
   logic            init_ram;
   logic [N-1:0]    req, req_we, gnt, rvalid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata, rdata;
   logic            ram_we_a, ram_re_a, ram_we_b, ram_re_b;
   logic [AW-1:0]   ram_addr_a, ram_addr_b;
   logic [DW-1:0]   ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;

   tdpram_port_arbiter #(.NUM_REQ(N), .RAM_WIDTH(DW), .RAM_DEPTH(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .gnt        (gnt),
      .rvalid     (rvalid),
      .rdata      (rdata),
      .ram_we_a   (ram_we_a),
      .ram_re_a   (ram_re_a),
      .ram_addr_a (ram_addr_a),
      .ram_din_a  (ram_din_a),
      .ram_dout_a (ram_dout_a),
      .ram_we_b   (ram_we_b),
      .ram_re_b   (ram_re_b),
      .ram_addr_b (ram_addr_b),
      .ram_din_b  (ram_din_b),
      .ram_dout_b (ram_dout_b)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int a);
      case (a)
         'h006:   return 16'hAAAA;
         'h010:   return 16'hBEEF;
         'h030:   return 16'h3C3C;
         default: return 16'((a * 40503) ^ 'h5A5A);
      endcase
   endfunction

   // Behavioural true dual-port RAM with registered read data.
   logic [DW-1:0] ram [1024];
   always @(posedge clk) begin
      if (init_ram) begin
         for (int a = 0; a < 1024; a++) ram[10'(a)] <= init_val(a);
      end else begin
         if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
         if (ram_re_a) ram_dout_a <= ram[ram_addr_a];
         if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
         if (ram_re_b) ram_dout_b <= ram[ram_addr_b];
      end
   end

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [AW-1:0] addr_of(input int i);
      return req_addr[i*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] wdata_of(input int i);
      return req_wdata[i*DW +: DW];
   endfunction

   // Expected {we, re, addr, din} for a port served by requester w (-1 = idle).
   function automatic logic [27:0] exp_port(input int w);
      if (w < 0) return '0;
      return {req_we[w], ~req_we[w], addr_of(w), wdata_of(w)};
   endfunction

   // ---------------- reference model and per-cycle compare ----------------
   logic [DW-1:0] model_mem [1024];
   logic [DW-1:0] pend_data [N];
   logic [DW-1:0] m_rdata   [N];
   logic [N-1:0]  pend, eg, acc_dut;
   int            m_ptr, wa, wb, cand;

   initial forever begin
      @(negedge clk);
      if (init_ram) begin
         for (int a = 0; a < 1024; a++) model_mem[a] = init_val(a);
         m_ptr = 0; pend = '0; acc_dut = '0;
         for (int i = 0; i < N; i++) m_rdata[i] = '0;
      end else if (rst) begin
         chk("rst_gnt", 64'(gnt), 64'd0);
         chk("rst_ram_en", 64'({ram_we_a, ram_re_a, ram_we_b, ram_re_b}), 64'd0);
         chk("rst_rvalid", 64'(rvalid), 64'd0);
         m_ptr = 0; pend = '0; acc_dut = '0;
         for (int i = 0; i < N; i++) m_rdata[i] = '0;
      end else begin
         // Collect requesters in cyclic order from the pointer.
         wa = -1; wb = -1;
         for (int k = 0; k < N; k++) begin
            cand = (m_ptr + k) % N;
            if (req[cand]) begin
               if (wa < 0)      wa = cand;
               else if (wb < 0) wb = cand;
            end
         end
         if (wb >= 0 && addr_of(wa) == addr_of(wb) && (req_we[wa] || req_we[wb])) wb = -1;
         eg = '0;
         if (wa >= 0) eg[wa] = 1'b1;
         if (wb >= 0) eg[wb] = 1'b1;

         chk("gnt", 64'(gnt), 64'(eg));
         chk("port_a", 64'({ram_we_a, ram_re_a, ram_addr_a, ram_din_a}), 64'(exp_port(wa)));
         chk("port_b", 64'({ram_we_b, ram_re_b, ram_addr_b, ram_din_b}), 64'(exp_port(wb)));
         chk("rvalid", 64'(rvalid), 64'(pend));
         for (int i = 0; i < N; i++) begin
            if (pend[i]) m_rdata[i] = pend_data[i];
            chk("rdata", 64'(rdata[i*DW +: DW]), 64'(m_rdata[i]));
         end

         pend = '0;
         if (wa >= 0 && !req_we[wa]) begin pend[wa] = 1'b1; pend_data[wa] = model_mem[addr_of(wa)]; end
         if (wb >= 0 && !req_we[wb]) begin pend[wb] = 1'b1; pend_data[wb] = model_mem[addr_of(wb)]; end
         if (wa >= 0 && req_we[wa]) model_mem[addr_of(wa)] = wdata_of(wa);
         if (wb >= 0 && req_we[wb]) model_mem[addr_of(wb)] = wdata_of(wb);
         if (wb >= 0)      m_ptr = (wb + 1) % N;
         else if (wa >= 0) m_ptr = (wa + 1) % N;
         acc_dut = gnt & req;
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i]               = 1'b1;
      req_we[i]            = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic rst_pulse;
      rst = 1'b1;
      req = '0;
      nxt;
      nxt;
      rst = 1'b0;
   endtask

   logic [N-1:0] g;
   int           wait_c [N];

   initial begin
      rst = 1'b1; init_ram = 1'b1;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < N; i++) wait_c[i] = 0;
      repeat (2) @(posedge clk);
      #1 init_ram = 1'b0;
      nxt;
      nxt;
      rst = 1'b0;

      // Single read on port A, data the following cycle.
      set_req(2, 1'b0, 10'h010, 16'h0);
      @(negedge clk);
      chk("t1_gnt", 64'(gnt), 64'b0100);
      chk("t1_en", 64'({ram_re_a, ram_we_a, ram_re_b, ram_we_b}), 64'b1000);
      chk("t1_addr", 64'(ram_addr_a), 64'h010);
      nxt; req = '0;
      @(negedge clk);
      chk("t1_rvalid", 64'(rvalid), 64'b0100);
      chk("t1_rdata", 64'(rdata[47:32]), 64'hBEEF);

      // Dual grant: write on A, read on B.
      nxt;
      set_req(0, 1'b1, 10'h005, 16'h1234);
      set_req(1, 1'b0, 10'h006, 16'h0);
      @(negedge clk);
      chk("t2_gnt", 64'(gnt), 64'b0011);
      chk("t2_en", 64'({ram_we_a, ram_re_a, ram_we_b, ram_re_b}), 64'b1001);
      chk("t2_porta", 64'({ram_addr_a, ram_din_a}), 64'({10'h005, 16'h1234}));
      chk("t2_addr_b", 64'(ram_addr_b), 64'h006);
      nxt; req = '0;
      @(negedge clk);
      chk("t2_rvalid", 64'(rvalid), 64'b0010);
      chk("t2_rdata", 64'(rdata[31:16]), 64'hAAAA);
      nxt; set_req(0, 1'b0, 10'h005, 16'h0);
      @(negedge clk);
      chk("t2_rd_gnt", 64'(gnt), 64'b0001);
      nxt; req = '0;
      @(negedge clk);
      chk("t2_readback", 64'(rdata[15:0]), 64'h1234);

      // Same-address write collision from a fresh pointer.
      nxt; rst_pulse;
      set_req(0, 1'b1, 10'h020, 16'h1111);
      set_req(1, 1'b1, 10'h020, 16'h2222);
      @(negedge clk);
      chk("t3_gnt1", 64'(gnt), 64'b0001);
      nxt; req[0] = 1'b0;
      @(negedge clk);
      chk("t3_gnt2", 64'(gnt), 64'b0010);
      nxt; req = '0; set_req(2, 1'b0, 10'h020, 16'h0);
      @(negedge clk);
      chk("t3_rd_gnt", 64'(gnt), 64'b0100);
      nxt; req = '0;
      @(negedge clk);
      chk("t3_rdata", 64'(rdata[47:32]), 64'h2222);
      chk("t3_ram", 64'(ram[10'h020]), 64'h2222);

      // Two reads of one address share a cycle.
      nxt;
      set_req(1, 1'b0, 10'h030, 16'h0);
      set_req(3, 1'b0, 10'h030, 16'h0);
      @(negedge clk);
      chk("t4_gnt", 64'(gnt), 64'b1010);
      nxt; req = '0;
      @(negedge clk);
      chk("t4_rvalid", 64'(rvalid), 64'b1010);
      chk("t4_rdata1", 64'(rdata[31:16]), 64'h3C3C);
      chk("t4_rdata3", 64'(rdata[63:48]), 64'h3C3C);

      // Round-robin rotation with all four requesters continuously reading.
      nxt; rst_pulse;
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++)
            if (!req[i]) set_req(i, 1'b0, 10'(32'h100 + c*4 + i), 16'h0);
         @(negedge clk);
         chk("t5_rotate", 64'(gnt), (c % 2 == 0) ? 64'b0011 : 64'b1100);
         g = gnt;
         nxt;
         req = req & ~g;
      end
      req = '0;

      // Reset one cycle after a read grant.
      set_req(1, 1'b0, 10'h040, 16'h0);
      @(negedge clk);
      chk("t6_gnt", 64'(gnt), 64'b0010);
      nxt;
      rst = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 10'(32'h200 + i), 16'h0);
      @(negedge clk);
      chk("t6_rvalid_rst", 64'(rvalid), 64'd0);
      chk("t6_gnt_rst", 64'(gnt), 64'd0);
      nxt;
      @(negedge clk);
      chk("t6_gnt_rst2", 64'(gnt), 64'd0);
      nxt;
      rst = 1'b0;
      req[3] = 1'b0;
      @(negedge clk);
      chk("t6_ptr0", 64'(gnt), 64'b0011);
      chk("t6_no_rvalid", 64'(rvalid), 64'd0);
      nxt; req = req & ~4'b0011;
      @(negedge clk);
      chk("t6_gnt_next", 64'(gnt), 64'b0100);
      nxt; req = '0;

      // Randomized traffic with narrow addresses to provoke conflicts.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         nxt;
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               if (acc_dut[i]) begin
                  chk("wait_bound", 64'(wait_c[i] <= N - 1), 64'd1);
                  wait_c[i] = 0;
                  req[i]    = 1'b0;
               end else begin
                  wait_c[i]++;
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(3) != 0) begin
               set_req(i, 1'($urandom_range(1)),
                       ($urandom_range(3) == 0) ? 10'($urandom_range(1023)) : 10'($urandom_range(7)),
                       16'($urandom));
               wait_c[i] = 0;
            end
         end
         if (cyc % 1000 == 999) begin
            rst_pulse;
            for (int i = 0; i < N; i++) wait_c[i] = 0;
         end
      end
      for (int i = 0; i < N; i++) chk("final_wait", 64'(wait_c[i] <= N - 1), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
